// File: rtl/tdp_ram_ctrl_if.sv
// Port bundle for the dual-port node RAM: two request ports plus read results and status pulses.
interface tdp_ram_ctrl_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
);
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [WIDTH-1:0]  dia;
    logic              enb;
    logic              web;
    logic [ADDR_W-1:0] addrb;
    logic [WIDTH-1:0]  dib;
    logic [WIDTH-1:0]  doa;
    logic [WIDTH-1:0]  dob;
    logic              vlda;
    logic              vldb;
    logic              coll;
    logic              oor;
    logic              init_done;

    modport master (
        output ena, wea, addra, dia, enb, web, addrb, dib,
        input  doa, dob, vlda, vldb, coll, oor, init_done
    );

    modport slave (
        input  ena, wea, addra, dia, enb, web, addrb, dib,
        output doa, dob, vlda, vldb, coll, oor, init_done
    );
endinterface

// File: rtl/tdp_ram_ctrl.sv
// True-dual-port node RAM with post-reset clear; read latency 1+OUT_REG, coll/oor one cycle after accept.
// No backpressure: each port accepts one request per cycle once init_done is high.
module tdp_ram_ctrl #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    tdp_ram_ctrl_if.slave  bus
);
    localparam logic [0:0]        S_CLEAR = 1'b0;
    localparam logic [0:0]        S_READY = 1'b1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic             ready;
    logic             acc_a, acc_b, inr_a, inr_b;
    logic             wr_a, wr_b, byp_a, byp_b;
    logic [WIDTH-1:0] mem_a, mem_b, nxt_a, nxt_b;
    logic [WIDTH-1:0] s1_doa, s1_dob;
    logic             s1_vlda, s1_vldb;
    logic             coll_q, oor_q;

    always_comb begin
        ready = (state == S_READY);
        acc_a = ready && bus.ena;
        acc_b = ready && bus.enb;
        inr_a = ({1'b0, bus.addra} < DEPTH_L);
        inr_b = ({1'b0, bus.addrb} < DEPTH_L);
        wr_a  = acc_a && bus.wea && inr_a;
        // Port A owns the entry when both ports write the same address.
        wr_b  = acc_b && bus.web && inr_b && !(wr_a && (bus.addra == bus.addrb));
        byp_a = wr_b && (bus.addrb == bus.addra);
        byp_b = wr_a && (bus.addra == bus.addrb);
        mem_a = inr_a ? mem[bus.addra] : '0;
        mem_b = inr_b ? mem[bus.addrb] : '0;

        nxt_a = s1_doa;
        if (bus.wea) begin
            if (RDW_MODE == 0)      nxt_a = bus.dia;
            else if (RDW_MODE == 1) nxt_a = mem_a;
        end else begin
            nxt_a = byp_a ? bus.dib : mem_a;
        end

        nxt_b = s1_dob;
        if (bus.web) begin
            if (RDW_MODE == 0)      nxt_b = bus.dib;
            else if (RDW_MODE == 1) nxt_b = mem_b;
        end else begin
            nxt_b = byp_b ? bus.dia : mem_b;
        end
    end

    // The array has no reset; the CLEAR walk zeroes it through the same write path.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[cnt] <= '0;
        end else begin
            if (wr_a) mem[bus.addra] <= bus.dia;
            if (wr_b) mem[bus.addrb] <= bus.dib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            cnt     <= '0;
            s1_doa  <= '0;
            s1_dob  <= '0;
            s1_vlda <= 1'b0;
            s1_vldb <= 1'b0;
            coll_q  <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            if (state == S_CLEAR) begin
                cnt <= cnt + ADDR_W'(1);
                if (cnt == LAST) state <= S_READY;
            end
            s1_vlda <= acc_a;
            s1_vldb <= acc_b;
            if (acc_a) s1_doa <= nxt_a;
            if (acc_b) s1_dob <= nxt_b;
            coll_q  <= acc_a && acc_b && bus.wea && bus.web && (bus.addra == bus.addrb);
            oor_q   <= (acc_a && !inr_a) || (acc_b && !inr_b);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] s2_doa, s2_dob;
            logic             s2_vlda, s2_vldb;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_doa  <= '0;
                    s2_dob  <= '0;
                    s2_vlda <= 1'b0;
                    s2_vldb <= 1'b0;
                end else begin
                    s2_doa  <= s1_doa;
                    s2_dob  <= s1_dob;
                    s2_vlda <= s1_vlda;
                    s2_vldb <= s1_vldb;
                end
            end
            assign bus.doa  = s2_doa;
            assign bus.dob  = s2_dob;
            assign bus.vlda = s2_vlda;
            assign bus.vldb = s2_vldb;
        end else begin : g_no_reg
            assign bus.doa  = s1_doa;
            assign bus.dob  = s1_dob;
            assign bus.vlda = s1_vlda;
            assign bus.vldb = s1_vldb;
        end
    endgenerate

    assign bus.coll      = coll_q;
    assign bus.oor       = oor_q;
    assign bus.init_done = ready;
endmodule

// File: doc/tdp_ram_ctrl.md
# tdp_ram_ctrl

Parametrised single-clock true-dual-port RAM for the hybrid-tree node storage. It generalises the existing two-port write-capable RAM with:
- a selectable read-during-write mode,
- an optional output register stage with per-port valid,
- deterministic cross-port collision resolution,
- a post-reset clear sequencer that zeroes every entry before accepting traffic.

Tree levels use it as the shared node array between the insert and pop pipelines.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 1024, number of entries (need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width
- RDW_MODE, 0, same-port read-during-write: 0 write-first, 1 read-first, 2 no-change
- OUT_REG, 0, 1 adds one output register stage to both ports
- clk  in  1  single clock for both ports
- rst_n  in  1  asynchronous, active-low reset
- init_done  out  1  high once the clear sequence has finished
- ena / enb  in  1  port enable
- wea / web  in  1  write enable (qualified by en)
- addra / addrb  in  ADDR_W  address
- dia / dib  in  WIDTH  write data
- doa / dob  out  WIDTH  read data
- vlda / vldb  out  1  doa/dob holds a result for an accepted request
- coll  out  1  one-cycle pulse: both ports wrote the same address
- oor  out  1  one-cycle pulse: an accepted request had address >= DEPTH

## Operation
- States: CLEAR → READY.
- rst_n low puts the block in CLEAR with clear counter = 0.
- **CLEAR:**
  - Each cycle writes 0 to entry cnt, then cnt++.
  - After the write to DEPTH-1, the next state is READY and init_done goes high.
  - Port requests are ignored: no writes, vld stays 0, coll/oor stay 0.
- **READY:** a request is accepted when en=1.
- **Write (we=1):** stores din at addr.
- **Same-port read data:**
  - Read (we=0): dout = mem[addr].
  - Write, RDW_MODE 0: dout = din.
  - Write, RDW_MODE 1: dout = old mem[addr].
  - Write, RDW_MODE 2: dout holds its previous value, but vld still pulses.
- **Cross-port, same address, same cycle:**
  - Both write: port A's data is stored, port B's write is dropped, coll=1.
  - Each port's dout follows its own RDW_MODE using its own din.
  - One reads, the other writes: the reader gets the writer's din (bypass). coll=0.
  - Both read: normal.
- **Out of range (addr >= DEPTH):**
  - Write is dropped.
  - Read returns 0.
  - vld still pulses and oor=1 (either port).
- en=0: dout holds its value and vld=0.
- **Reset values:**
  - doa, dob, vlda, vldb, coll, oor, init_done = 0.
  - Internal output registers = 0.
  - Array contents are not reset asynchronously; they are cleared by the CLEAR sequence.
- Reset asserted mid-CLEAR or mid-READY: all outputs go to reset values immediately and the clear restarts from entry 0. Any in-flight pipeline result is discarded.

## Timing
- CLEAR lasts exactly DEPTH cycles after the first clk edge with rst_n high. init_done rises on the DEPTH-th edge.
- Read latency is 1+OUT_REG cycles from the accepting edge to dout/vld.
- With OUT_REG=1, the second stage register always advances.
- vld is asserted exactly on the cycle dout carries the result; it is a single-cycle pulse per accepted request.
- Back-to-back requests at full throughput on both ports, one per port per cycle.
- coll and oor are registered: asserted 1 cycle after the accepting edge, independent of OUT_REG.
- A write is visible to a read issued on the following cycle, on either port.

## Test plan
- **Clear sequence.** Reset, DEPTH=8. Hold ena=1, wea=1 during CLEAR.
  - init_done rises after 8 cycles and vlda stays 0.
  - Reading all 8 entries then returns 0.
- **Write modes, OUT_REG=0.** mem[5]=0x1111, then port A writes 0x2222 to 5.
  - doa next cycle: 0x2222 in mode 0, 0x1111 in mode 1, unchanged in mode 2.
  - vlda=1 in all three modes.
- **Write collision.** Both ports write addr 3 (A=0xAAAA, B=0xBBBB).
  - coll pulses 1 cycle later.
  - A subsequent read of 3 returns 0xAAAA.
- **Cross-port bypass.** A writes 0x1234 to 7 while B reads 7.
  - dob=0x1234 with vldb=1 one cycle later (two cycles with OUT_REG=1).
- **Out of range.** DEPTH=10. Write 0xFFFF to addr 12, then read addr 12.
  - oor pulses for both requests and the read returns 0.
  - Entries 0–9 are unchanged.
- **Reset mid-operation.** Assert rst_n low mid-READY with a read in flight (OUT_REG=1).
  - vlda=0 immediately and init_done=0.
  - CLEAR reruns; previously written data reads as 0 afterwards.
